calc1_scoreboard: RTL
=====================

// Module: calc1_scoreboard
// PURPOSE
//  Passive monitor on the calc1 request/response interface, alongside the checker in the calc1 bench.
//  Tracks the outstanding command on each of the 4 ports and measures per-port response latency.
//  Flags protocol violations, timeouts and scheduling starvation (one port left waiting while others complete).
//  Observes only and never drives the DUV.
// PARAMETERS
//  LAT_W         8    width of latency counters; all latency counters saturate at 2**LAT_W-1
//  TIMEOUT       64   cycles in WAIT before err_timeout is set
//  STARVE_LIMIT  8    other-port completions tolerated while a port waits
//  CNT_W         16   width of total-response counter; saturates
// PORTS
//  c_clk        in   1        single clock; all sampling on posedge
//  reset        in   1        asynchronous, active-low reset
//  req_cmd_in   in   16       port p cmd at bits [4(p-1) +: 4], p=1..4; 0 = no command
//  out_resp     in   8        port p resp at bits [2(p-1) +: 2]; 0 = none, 1 ok, 2 ovf/unf, 3 invalid
//  clear_err    in   1        synchronous pulse; clears all sticky error flags
//  busy         out  4        bit p-1 = port p has a command outstanding
//  err_proto    out  4        sticky: cmd while busy, or resp while idle
//  err_timeout  out  4        sticky: port waited TIMEOUT cycles
//  err_starve   out  4        sticky: > STARVE_LIMIT other-port completions while waiting
//  max_lat      out  4*LAT_W  per-port worst latency seen; port p at [LAT_W(p-1) +: LAT_W]
//  resp_count   out  CNT_W    total valid responses across all ports
// BEHAVIOUR
//  - Reset (reset=0, async): every output = 0; all ports IDLE; all internal counters = 0.
//  - Reset mid-operation: outstanding commands are discarded; no error is raised for them after release.
//  - Per-port FSM: IDLE, WAIT.
//    IDLE + cmd!=0 -> WAIT; lat_cnt <= 0; starve_cnt <= 0.
//    IDLE + resp!=0 -> set err_proto[p]; stay IDLE.
//    WAIT: lat_cnt increments each cycle (saturating).
//    WAIT + resp!=0 -> IDLE. Latency = lat_cnt+1; max_lat <= max(max_lat, latency).
//    WAIT + resp!=0 + cmd!=0 in the same cycle -> back-to-back issue. Record the completed latency,
//      stay WAIT, reset lat_cnt and starve_cnt to 0. No error.
//    WAIT + cmd!=0 + resp==0 -> set err_proto[p]. Keep the original command timing (no counter reset).
//    WAIT with lat_cnt+1 == TIMEOUT -> set err_timeout[p]. Remain WAIT; a late response still closes
//      the command normally.
//  - Starvation: each cycle a WAIT port adds the number of OTHER ports completing that cycle (0..3)
//      to starve_cnt (saturating). starve_cnt > STARVE_LIMIT -> set err_starve[p].
//  - resp_count += number of resp!=0 accepted in WAIT this cycle (0..4), saturating. Responses that
//      raise err_proto are not counted.
//  - Error flags and outputs update on the posedge that samples the event (1-cycle latency).
//  - clear_err clears all err_* flags. An event in the same cycle as clear_err wins (flag stays set).
//  - Response code value (1/2/3) does not affect tracking; all nonzero codes complete a command.
// STRUCTURE
//  - Package calc1_sb_pkg: RESP_NONE/OK/OVF/INV codes, CMD_NOP=4'h0, port-state enum {SB_IDLE, SB_WAIT},
//    and a saturating-increment function.
//  - Sub-module calc1_sb_port: one FSM plus lat_cnt, starve_cnt, max_lat and the three flags.
//    Instantiated 4x via generate.
//  - Top level: input slicing, per-port "other completions" sum, resp_count adder, clear_err fan-out.
// TESTING
//  1. Port1 cmd=1 at cycle 0, resp=1 at cycle 5 -> busy[0] high cycles 1-5; max_lat[p1]=5;
//     resp_count=1; no errors.
//  2. Port2 resp=1 while IDLE -> err_proto[1]=1 next cycle; resp_count unchanged;
//     clear_err pulse -> err_proto=0.
//  3. Port3 cmd, no resp for 70 cycles, with TIMEOUT=64 -> err_timeout[2] set after 64 cycles;
//     resp at cycle 70 -> busy[2]=0, max_lat=70.
//  4. Port4 waits while ports 1-3 complete 3 cmds each (9 completions), STARVE_LIMIT=8 -> err_starve[3]=1
//     on the 9th completion; other ports have no errors.
//  5. Port1 resp and new cmd in the same cycle -> busy stays 1, no err_proto, lat_cnt restarts,
//     resp_count increments.
//  6. Ports 1-4 all WAIT, reset asserted low mid-wait -> all outputs 0 immediately (async);
//     after release, responses on all ports -> err_proto=4'b1111.

Source files
------------

// File: rtl/calc1_sb_pkg.sv
// calc1_sb_pkg: shared definitions for the calc1 request/response scoreboard.
//   - response codes and the no-command encoding
//   - per-port tracking state
//   - saturating adder used by every counter in the scoreboard
package calc1_sb_pkg;

    localparam logic [1:0] RESP_NONE = 2'd0;
    localparam logic [1:0] RESP_OK   = 2'd1;
    localparam logic [1:0] RESP_OVF  = 2'd2;
    localparam logic [1:0] RESP_INV  = 2'd3;

    localparam logic [3:0] CMD_NOP   = 4'h0;

    typedef enum logic {
        SB_IDLE = 1'b0,
        SB_WAIT = 1'b1
    } sb_state_t;

    // a + b, clamped to max_val. Callers zero-extend narrower counters to 32 bits.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] max_val);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, max_val}) ? max_val : sum[31:0];
    endfunction

endpackage

// File: rtl/calc1_sb_port.sv
// calc1_sb_port: tracker for one calc1 port.
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_cmd            command nibble for this port (CMD_NOP = none)
//   i_resp           response code for this port (RESP_NONE = none)
//   i_clear          clears the sticky error flags
//   i_others         completions on the other three ports this cycle (0..3)
//   o_busy           command outstanding
//   o_complete       a response is being accepted this cycle (combinational)
//   o_err_proto      sticky: command while busy, or response while idle
//   o_err_timeout    sticky: waited TIMEOUT cycles
//   o_err_starve     sticky: more than STARVE_LIMIT other completions while waiting
//   o_max_lat        worst completed latency
module calc1_sb_port
    import calc1_sb_pkg::*;
#(
    parameter int LAT_W        = 8,
    parameter int TIMEOUT      = 64,
    parameter int STARVE_LIMIT = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [3:0]       i_cmd,
    input  logic [1:0]       i_resp,
    input  logic             i_clear,
    input  logic [1:0]       i_others,
    output logic             o_busy,
    output logic             o_complete,
    output logic             o_err_proto,
    output logic             o_err_timeout,
    output logic             o_err_starve,
    output logic [LAT_W-1:0] o_max_lat
);

    localparam logic [31:0] LAT_MAX = 32'((64'd1 << LAT_W) - 64'd1);

    sb_state_t        r_state;
    logic [LAT_W-1:0] r_lat_cnt;
    logic [LAT_W-1:0] r_starve_cnt;
    logic [LAT_W-1:0] r_max_lat;
    logic             r_err_proto;
    logic             r_err_timeout;
    logic             r_err_starve;

    logic             w_cmd_v;
    logic             w_resp_v;
    logic             w_wait;
    logic [LAT_W-1:0] w_lat_inc;
    logic [LAT_W-1:0] w_starve_nxt;
    logic             w_proto_hit;
    logic             w_timeout_hit;
    logic             w_starve_hit;

    always_comb begin
        w_cmd_v       = (i_cmd != CMD_NOP);
        w_resp_v      = (i_resp != RESP_NONE);
        w_wait        = (r_state == SB_WAIT);
        // Saturated lat_cnt+1 doubles as next count and as the completed latency.
        w_lat_inc     = LAT_W'(sat_add(32'(r_lat_cnt), 32'd1, LAT_MAX));
        w_starve_nxt  = LAT_W'(sat_add(32'(r_starve_cnt), 32'(i_others), LAT_MAX));
        w_proto_hit   = (!w_wait && w_resp_v) || (w_wait && w_cmd_v && !w_resp_v);
        // Unsaturated compare so the flag fires exactly once per command.
        w_timeout_hit = w_wait && ((33'(r_lat_cnt) + 33'd1) == 33'(TIMEOUT));
        w_starve_hit  = w_wait && (32'(w_starve_nxt) > 32'(STARVE_LIMIT));
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= SB_IDLE;
            r_lat_cnt     <= '0;
            r_starve_cnt  <= '0;
            r_max_lat     <= '0;
            r_err_proto   <= 1'b0;
            r_err_timeout <= 1'b0;
            r_err_starve  <= 1'b0;
        end else begin
            // A same-cycle event beats the clear.
            r_err_proto   <= (r_err_proto   & ~i_clear) | w_proto_hit;
            r_err_timeout <= (r_err_timeout & ~i_clear) | w_timeout_hit;
            r_err_starve  <= (r_err_starve  & ~i_clear) | w_starve_hit;

            case (r_state)
                SB_IDLE: begin
                    if (w_cmd_v) begin
                        r_state      <= SB_WAIT;
                        r_lat_cnt    <= '0;
                        r_starve_cnt <= '0;
                    end
                end
                SB_WAIT: begin
                    if (w_resp_v) begin
                        if (w_lat_inc > r_max_lat)
                            r_max_lat <= w_lat_inc;
                        if (w_cmd_v) begin
                            // Back-to-back issue: new command timing starts now.
                            r_lat_cnt    <= '0;
                            r_starve_cnt <= '0;
                        end else begin
                            r_state <= SB_IDLE;
                        end
                    end else begin
                        r_lat_cnt    <= w_lat_inc;
                        r_starve_cnt <= w_starve_nxt;
                    end
                end
                default: r_state <= SB_IDLE;
            endcase
        end
    end

    assign o_busy        = (r_state == SB_WAIT);
    assign o_complete    = w_wait && w_resp_v;
    assign o_err_proto   = r_err_proto;
    assign o_err_timeout = r_err_timeout;
    assign o_err_starve  = r_err_starve;
    assign o_max_lat     = r_max_lat;

endmodule

// File: rtl/calc1_scoreboard.sv
// calc1_scoreboard: passive monitor on the 4-port calc1 request/response interface.
//   c_clk        clock (posedge sampling)
//   reset        asynchronous active-low reset
//   req_cmd_in   port p command at [4(p-1) +: 4]
//   out_resp     port p response at [2(p-1) +: 2]
//   clear_err    clears all sticky error flags
//   busy         per-port command outstanding
//   err_proto    per-port sticky protocol error
//   err_timeout  per-port sticky timeout
//   err_starve   per-port sticky starvation
//   max_lat      per-port worst latency, port p at [LAT_W(p-1) +: LAT_W]
//   resp_count   total accepted responses, saturating
module calc1_scoreboard
    import calc1_sb_pkg::*;
#(
    parameter int LAT_W        = 8,
    parameter int TIMEOUT      = 64,
    parameter int STARVE_LIMIT = 8,
    parameter int CNT_W        = 16
) (
    input  logic               c_clk,
    input  logic               reset,
    input  logic [15:0]        req_cmd_in,
    input  logic [7:0]         out_resp,
    input  logic               clear_err,
    output logic [3:0]         busy,
    output logic [3:0]         err_proto,
    output logic [3:0]         err_timeout,
    output logic [3:0]         err_starve,
    output logic [4*LAT_W-1:0] max_lat,
    output logic [CNT_W-1:0]   resp_count
);

    localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

    logic [3:0]       w_complete;
    logic [2:0]       w_total;
    logic [1:0]       w_others [4];
    logic [CNT_W-1:0] r_resp_count;

    always_comb begin
        w_total = 3'(w_complete[0]) + 3'(w_complete[1])
                + 3'(w_complete[2]) + 3'(w_complete[3]);
        for (int unsigned p = 0; p < 4; p++)
            w_others[p] = 2'(w_total - 3'(w_complete[p]));
    end

    for (genvar p = 0; p < 4; p++) begin : g_port
        calc1_sb_port #(
            .LAT_W        (LAT_W),
            .TIMEOUT      (TIMEOUT),
            .STARVE_LIMIT (STARVE_LIMIT)
        ) u_port (
            .i_clk         (c_clk),
            .i_rst_n       (reset),
            .i_cmd         (req_cmd_in[4*p +: 4]),
            .i_resp        (out_resp[2*p +: 2]),
            .i_clear       (clear_err),
            .i_others      (w_others[p]),
            .o_busy        (busy[p]),
            .o_complete    (w_complete[p]),
            .o_err_proto   (err_proto[p]),
            .o_err_timeout (err_timeout[p]),
            .o_err_starve  (err_starve[p]),
            .o_max_lat     (max_lat[LAT_W*p +: LAT_W])
        );
    end

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset)
            r_resp_count <= '0;
        else
            r_resp_count <= CNT_W'(sat_add(32'(r_resp_count), 32'(w_total), CNT_MAX));
    end

    assign resp_count = r_resp_count;

endmodule
